div_unit: RTL and testbench

DIV_UNIT -- requirements
Module: div_unit

---
 rtl/div_unit.sv | 116 +++++++++++
 tb/tb_div_unit.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/div_unit.sv
// 32-bit signed/unsigned restoring divider with one quotient bit per cycle; result 34 edges after start (2 for a zero divisor).
// No backpressure: the EX stage holds start_i until ready_o, then drops it to release the result.
module div_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        signed_div_i,
    input  logic [31:0] opdata1_i,
    input  logic [31:0] opdata2_i,
    input  logic        start_i,
    input  logic        annul_i,
    output logic [63:0] result_o,
    output logic        ready_o,
    output logic        busy_o
);

    localparam logic [1:0] S_FREE   = 2'd0;
    localparam logic [1:0] S_BYZERO = 2'd1;
    localparam logic [1:0] S_ON     = 2'd2;
    localparam logic [1:0] S_END    = 2'd3;

    logic [1:0]  state;
    logic [5:0]  cnt;
    logic [64:0] working;
    logic [31:0] divisor;
    logic        neg_quo;
    logic        neg_rem;

    logic [31:0] abs_op1;
    logic [31:0] abs_op2;
    logic [32:0] trial;
    logic [31:0] quo_fix;
    logic [31:0] rem_fix;

    assign abs_op1 = (signed_div_i && opdata1_i[31]) ? (~opdata1_i + 32'd1) : opdata1_i;
    assign abs_op2 = (signed_div_i && opdata2_i[31]) ? (~opdata2_i + 32'd1) : opdata2_i;

    // Bit 32 of the trial is the borrow: set means the divisor did not fit.
    assign trial   = {1'b0, working[63:32]} - {1'b0, divisor};
    assign quo_fix = neg_quo ? (~working[31:0] + 32'd1) : working[31:0];
    assign rem_fix = neg_rem ? (~working[64:33] + 32'd1) : working[64:33];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= S_FREE;
            cnt      <= 6'd0;
            working  <= 65'd0;
            divisor  <= 32'd0;
            neg_quo  <= 1'b0;
            neg_rem  <= 1'b0;
            result_o <= 64'd0;
            ready_o  <= 1'b0;
            busy_o   <= 1'b0;
        end else begin
            case (state)
                S_FREE: begin
                    if (start_i && !annul_i) begin
                        busy_o <= 1'b1;
                        if (opdata2_i == 32'd0) begin
                            state <= S_BYZERO;
                        end else begin
                            state   <= S_ON;
                            cnt     <= 6'd0;
                            // Dividend sits one bit up so the first trial already sees its MSB.
                            working <= {32'd0, abs_op1, 1'b0};
                            divisor <= abs_op2;
                            neg_quo <= signed_div_i && (opdata1_i[31] ^ opdata2_i[31]);
                            neg_rem <= signed_div_i && opdata1_i[31];
                        end
                    end
                end
                S_BYZERO: begin
                    working <= 65'd0;
                    state   <= S_END;
                end
                S_ON: begin
                    if (annul_i) begin
                        state    <= S_FREE;
                        cnt      <= 6'd0;
                        working  <= 65'd0;
                        result_o <= 64'd0;
                        ready_o  <= 1'b0;
                        busy_o   <= 1'b0;
                    end else if (cnt != 6'd32) begin
                        if (!trial[32]) begin
                            working <= {trial[31:0], working[31:0], 1'b1};
                        end else begin
                            working <= {working[63:0], 1'b0};
                        end
                        cnt <= cnt + 6'd1;
                    end else begin
                        // Signs are restored in place; END presents {remainder, quotient}.
                        working <= {rem_fix, 1'b0, quo_fix};
                        cnt     <= 6'd0;
                        state   <= S_END;
                    end
                end
                S_END: begin
                    if (start_i) begin
                        result_o <= {working[64:33], working[31:0]};
                        ready_o  <= 1'b1;
                    end else begin
                        result_o <= 64'd0;
                        ready_o  <= 1'b0;
                        busy_o   <= 1'b0;
                        state    <= S_FREE;
                    end
                end
                default: begin
                    state  <= S_FREE;
                    busy_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// Randomized and directed checks of div_unit against a truncating-division reference model.
module tb_div_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        signed_div_i;
    logic [31:0] opdata1_i;
    logic [31:0] opdata2_i;
    logic        start_i;
    logic        annul_i;
    logic [63:0] result_o;
    logic        ready_o;
    logic        busy_o;

    int errors = 0;
    int checks = 0;

    div_unit dut (
        .clk          (clk),
        .rst          (rst),
        .signed_div_i (signed_div_i),
        .opdata1_i    (opdata1_i),
        .opdata2_i    (opdata2_i),
        .start_i      (start_i),
        .annul_i      (annul_i),
        .result_o     (result_o),
        .ready_o      (ready_o),
        .busy_o       (busy_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // {remainder, quotient}; quotient truncates toward zero, remainder takes the dividend's sign.
    function automatic logic [63:0] model(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] ma, mb, q, r;
        logic        na, nb;
        if (b == 32'd0) return 64'd0;
        na = sgn && a[31];
        nb = sgn && b[31];
        ma = na ? -a : a;
        mb = nb ? -b : b;
        q  = ma / mb;
        r  = ma % mb;
        if (na != nb) q = -q;
        if (na) r = -r;
        return {r, q};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_div(input string tag, input logic sgn, input logic [31:0] a,
                           input logic [31:0] b, input logic [63:0] exp);
        int          lat;
        int          busy_low;
        int          exp_lat;
        logic [31:0] rnd;
        exp_lat      = (b == 32'd0) ? 2 : 34;
        signed_div_i = sgn;
        opdata1_i    = a;
        opdata2_i    = b;
        annul_i      = 1'b0;
        start_i      = 1'b1;
        tick();
        lat      = 0;
        busy_low = 0;
        while (!ready_o && lat < 60) begin
            if (!busy_o) busy_low++;
            rnd          = $urandom;
            opdata1_i    = $urandom;
            opdata2_i    = $urandom;
            signed_div_i = rnd[0];
            tick();
            lat++;
        end
        chk({tag, " latency"}, 64'(lat), 64'(exp_lat));
        chk({tag, " result"}, result_o, exp);
        chk({tag, " busy"}, 64'(busy_low), 64'd0);
        annul_i = 1'b1;
        tick();
        tick();
        chk({tag, " hold"}, {ready_o, busy_o}, 2'b11);
        chk({tag, " hold result"}, result_o, exp);
        start_i = 1'b0;
        tick();
        annul_i = 1'b0;
        chk({tag, " release"}, {ready_o, busy_o}, 2'b00);
        chk({tag, " release result"}, result_o, 64'd0);
    endtask

    initial begin
        int          bad;
        logic        sgn;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] rnd;

        rst          = 1'b0;
        start_i      = 1'b0;
        annul_i      = 1'b0;
        signed_div_i = 1'b0;
        opdata1_i    = 32'd0;
        opdata2_i    = 32'd0;
        #1;
        chk("reset result", result_o, 64'd0);
        chk("reset flags", {ready_o, busy_o}, 2'b00);
        repeat (2) @(negedge clk);
        rst = 1'b1;

        run_div("u100_7", 1'b0, 32'd100, 32'd7, 64'h00000002_0000000E);
        run_div("s_m7_2", 1'b1, 32'hFFFFFFF9, 32'd2, 64'hFFFFFFFF_FFFFFFFD);
        run_div("u_m7_2", 1'b0, 32'hFFFFFFF9, 32'd2, 64'h00000001_7FFFFFFC);
        run_div("s_7_m2", 1'b1, 32'd7, 32'hFFFFFFFE, 64'h00000001_FFFFFFFD);
        run_div("s_min_m1", 1'b1, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000);
        run_div("u_max_1", 1'b0, 32'hFFFFFFFF, 32'd1, 64'h00000000_FFFFFFFF);
        run_div("zero_div", 1'b0, 32'h00001234, 32'd0, 64'd0);
        run_div("s_zero_div", 1'b1, 32'h80000000, 32'd0, 64'd0);

        // Start is ignored while annul is high in FREE.
        annul_i   = 1'b1;
        start_i   = 1'b1;
        opdata1_i = 32'd50;
        opdata2_i = 32'd5;
        repeat (3) tick();
        chk("annul_free", {ready_o, busy_o}, 2'b00);
        annul_i = 1'b0;
        start_i = 1'b0;
        tick();

        // Abandon a division after 10 iterations, then restart immediately.
        signed_div_i = 1'b0;
        opdata1_i    = 32'd100;
        opdata2_i    = 32'd7;
        start_i      = 1'b1;
        tick();
        bad = 0;
        repeat (10) begin
            tick();
            if (ready_o) bad++;
        end
        annul_i = 1'b1;
        tick();
        if (ready_o) bad++;
        chk("annul_on flags", {ready_o, busy_o}, 2'b00);
        chk("annul_on result", result_o, 64'd0);
        chk("annul_on no ready", 64'(bad), 64'd0);
        run_div("after_annul", 1'b0, 32'd9, 32'd3, 64'h00000000_00000003);

        // Asynchronous reset in the middle of a division.
        signed_div_i = 1'b0;
        opdata1_i    = 32'd100;
        opdata2_i    = 32'd7;
        start_i      = 1'b1;
        tick();
        repeat (20) tick();
        #2;
        rst = 1'b0;
        #1;
        chk("mid_reset result", result_o, 64'd0);
        chk("mid_reset flags", {ready_o, busy_o}, 2'b00);
        @(negedge clk);
        rst     = 1'b1;
        start_i = 1'b0;
        bad     = 0;
        repeat (40) begin
            tick();
            if (ready_o || busy_o) bad++;
        end
        chk("post_reset idle", 64'(bad), 64'd0);
        run_div("post_reset", 1'b1, 32'hFFFFFF9C, 32'd7, 64'hFFFFFFFE_FFFFFFF2);

        for (int i = 0; i < 16; i++) begin
            rnd = $urandom;
            sgn = rnd[0];
            a   = $urandom;
            case (rnd[3:1])
                3'd0:    b = 32'd0;
                3'd1:    b = 32'd1 + 32'($urandom_range(15, 0));
                3'd2:    b = 32'hFFFFFFFF - 32'($urandom_range(15, 0));
                3'd3:    b = a;
                default: b = $urandom >> rnd[8:4];
            endcase
            run_div($sformatf("rand%0d", i), sgn, a, b, model(sgn, a, b));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
